flash_cmd_engine: RTL and testbench

- Executes the flash write and erase commands posted by the register file; it is the responder for the FlashOp* command interface.
- Reads staged 16-bit words from the flash-write storage RAM, which the register file fills through its write port.
- Drives the on-chip user flash through its Avalon-MM CSR and data ports, and reports progress back via FlashCmdAck, FlashBusy and FlashError.

---
 rtl/flash_pkg.sv | 31 +++
 rtl/flash_timeout_ctr.sv | 16 +
 rtl/flash_cmd_engine.sv | 125 ++++++++++++
 tb/tb_flash_cmd_engine.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// flash_pkg: state encoding, CSR field layout and shared constants for the flash command engine.
package flash_pkg;
   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_WP_OFF   = 4'd1;
   localparam logic [3:0] S_ERASE    = 4'd2;
   localparam logic [3:0] S_FETCH_HI = 4'd3;
   localparam logic [3:0] S_FETCH_LO = 4'd4;
   localparam logic [3:0] S_WR_REQ   = 4'd5;
   localparam logic [3:0] S_POLL     = 4'd6;
   localparam logic [3:0] S_WP_ON    = 4'd7;
   localparam logic [3:0] S_DONE     = 4'd8;
   localparam logic [3:0] S_VERIFY   = 4'd9;
   localparam int BUSY_LSB  = 0;
   localparam int WR_OK_BIT = 3;
   localparam int ER_OK_BIT = 4;
   localparam logic CSR_STATUS = 1'b0;
   localparam logic CSR_CTRL   = 1'b1;
   localparam logic [19:0] PAGE_NONE  = 20'hFFFFF;
   localparam logic [15:0] UNLOCK_KEY = 16'hDAF0;
   typedef struct packed {
      logic [3:0]  rsvd;
      logic [4:0]  wp;
      logic [2:0]  sector;
      logic [19:0] page;
   } ctrl_t;
   function automatic logic [31:0] ctrl_word(input logic [4:0] wp, input logic [19:0] page);
      ctrl_t c;
      c = '{rsvd: 4'hF, wp: wp, sector: 3'b111, page: page};
      return c;
   endfunction
endpackage

// File: rtl/flash_timeout_ctr.sv
// flash_timeout_ctr: per-wait-state cycle counter; expired holds once LIMIT cycles have elapsed since load.
module flash_timeout_ctr #(
   parameter int           W     = 24,
   parameter logic [W-1:0] LIMIT = '1
) (
   input  logic Clock,
   input  logic Reset,
   input  logic load,
   input  logic en,
   output logic expired
);
   logic [W-1:0] cnt;
   assign expired = cnt == LIMIT;
   always_ff @(posedge Clock)
      cnt <= Reset || load ? '0 : en && !expired ? cnt + W'(1) : cnt;
endmodule

// File: rtl/flash_cmd_engine.sv
// flash_cmd_engine: executes FlashOp write/erase commands against the user flash Avalon CSR/data ports.
// Optional read-back check after each written word when FLASH_VERIFY_EN is defined.
module flash_cmd_engine
   import flash_pkg::*;
#(
   parameter int          ADDR_W         = 18,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000,
   parameter logic [4:0]  WP_BITS        = 5'b11111
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [17:0]       FlashOpAddr,
   input  logic [5:0]        FlashOpLen,
   input  logic              FlashOpUnlock,
   input  logic              FlashOpWr,
   input  logic              FlashOpEr,
   output logic              FlashCmdAck,
   output logic              FlashBusy,
   output logic              FlashError,
   output logic [6:0]        BufRdAddress,
   input  logic [15:0]       BufRdData,
   output logic              CsrAddress,
   output logic              CsrRead,
   input  logic [31:0]       CsrReadData,
   output logic              CsrWrite,
   output logic [31:0]       CsrWriteData,
   output logic [ADDR_W-1:0] DataAddress,
   output logic              DataWrite,
   output logic [31:0]       DataWriteData,
   input  logic              DataWaitRequest
`ifdef FLASH_VERIFY_EN
  ,output logic              DataRead,
   input  logic [31:0]       DataReadData,
   input  logic              DataReadDataValid
`endif
);
   logic [3:0] state, nxt, write_next, after_wr;
   logic [ADDR_W-1:0] addr;
   logic [5:0] len, idx;
   logic [1:0] poll_cnt;
   logic is_erase, expired, accept, bad, wr_done, poll_done, ok_bit, rd_done, rd_bad, err_set, waiting;
   logic unused_csr;
   assign unused_csr = ^{CsrReadData[31:5], CsrReadData[2]};
   assign accept     = state == S_IDLE && FlashOpUnlock && (FlashOpWr || FlashOpEr);
   assign bad        = FlashOpWr && (FlashOpEr || FlashOpLen == 6'd0);
   assign wr_done    = state == S_WR_REQ && !DataWaitRequest;
   assign poll_done  = state == S_POLL && poll_cnt == 2'd1 && CsrReadData[BUSY_LSB +: 2] == 2'b00;
   assign ok_bit     = is_erase ? CsrReadData[ER_OK_BIT] : CsrReadData[WR_OK_BIT];
   assign write_next = idx == len ? S_WP_ON : S_FETCH_HI;
   assign waiting    = state == S_WR_REQ || state == S_POLL || state == S_VERIFY;
`ifdef FLASH_VERIFY_EN
   logic rd_acc;
   assign after_wr = S_VERIFY;
   assign DataRead = state == S_VERIFY && !rd_acc;
   assign rd_done  = state == S_VERIFY && rd_acc && DataReadDataValid;
   assign rd_bad   = rd_done && DataReadData != DataWriteData;
   always_ff @(posedge Clock)
      rd_acc <= !Reset && state == S_VERIFY && (rd_acc || !DataWaitRequest);
`else
   assign after_wr = write_next;
   assign rd_done  = 1'b0;
   assign rd_bad   = 1'b0;
`endif
   assign err_set = (state == S_WR_REQ && !wr_done && expired)
                 || (state == S_POLL && (poll_done ? !ok_bit : expired))
                 || (state == S_VERIFY && (rd_done ? rd_bad : expired));
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:     nxt = accept ? (bad ? S_DONE : S_WP_OFF) : S_IDLE;
         S_WP_OFF:   nxt = is_erase ? S_ERASE : S_FETCH_HI;
         S_ERASE:    nxt = S_POLL;
         S_FETCH_HI: nxt = S_FETCH_LO;
         S_FETCH_LO: nxt = S_WR_REQ;
         S_WR_REQ:   nxt = wr_done ? S_POLL : expired ? S_WP_ON : S_WR_REQ;
         S_POLL:     nxt = poll_done ? (is_erase || !ok_bit ? S_WP_ON : after_wr) : expired ? S_WP_ON : S_POLL;
         S_VERIFY:   nxt = rd_done ? (rd_bad ? S_WP_ON : write_next) : expired ? S_WP_ON : S_VERIFY;
         S_WP_ON:    nxt = S_DONE;
         default:    nxt = S_IDLE;
      endcase
   end
   flash_timeout_ctr #(.W(24), .LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .Clock(Clock), .Reset(Reset), .load(nxt != state), .en(waiting), .expired(expired)
   );
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state         <= S_IDLE;
         FlashCmdAck   <= 1'b0;
         FlashBusy     <= 1'b0;
         FlashError    <= 1'b0;
         addr          <= '0;
         len           <= 6'd0;
         idx           <= 6'd0;
         is_erase      <= 1'b0;
         poll_cnt      <= 2'd0;
         DataWriteData <= 32'd0;
      end else begin
         state       <= nxt;
         FlashCmdAck <= accept;
         FlashBusy   <= nxt != S_IDLE;
         FlashError  <= accept ? bad : FlashError | err_set;
         if (accept) begin
            addr     <= ADDR_W'(FlashOpAddr);
            len      <= FlashOpLen;
            idx      <= 6'd0;
            is_erase <= FlashOpEr;
         end
         if (wr_done) idx <= idx + 6'd1;
         poll_cnt <= state == S_POLL ? poll_cnt + 2'd1 : 2'd0;
         if (state == S_FETCH_HI) DataWriteData[31:16] <= BufRdData;
         if (state == S_FETCH_LO) DataWriteData[15:0] <= BufRdData;
      end
   end
   // idx advances when a word completes, so the RAM already holds entry 2i when FETCH_HI samples it
   assign BufRdAddress = {idx, state == S_FETCH_HI};
   assign CsrWrite     = state == S_WP_OFF || state == S_ERASE || state == S_WP_ON;
   assign CsrAddress   = CsrWrite ? CSR_CTRL : CSR_STATUS;
   assign CsrRead      = state == S_POLL && poll_cnt == 2'd0;
   assign CsrWriteData = state == S_WP_OFF ? ctrl_word(5'b0, PAGE_NONE)
                       : state == S_ERASE  ? ctrl_word(5'b0, 20'(addr))
                       : state == S_WP_ON  ? ctrl_word(WP_BITS, PAGE_NONE) : 32'd0;
   assign DataWrite    = state == S_WR_REQ;
   assign DataAddress  = DataWrite ? addr + ADDR_W'(idx)
                       : state == S_VERIFY ? addr + ADDR_W'(idx) - ADDR_W'(1) : '0;
endmodule

// File: tb/tb_flash_cmd_engine.sv
// tb_flash_cmd_engine: directed stimulus with a scoreboard of expected acks, CSR writes, data writes and end status.
module tb_flash_cmd_engine;
   localparam logic [23:0] TMO = 24'd100;
   localparam logic [31:0] WP_OFF_W = 32'hF07FFFFF;
   localparam logic [31:0] WP_ON_W  = 32'hFFFFFFFF;
   logic Clock = 1'b0, Reset = 1'b1;
   logic [17:0] FlashOpAddr = '0;
   logic [5:0]  FlashOpLen = '0;
   logic FlashOpUnlock = 1'b0, FlashOpWr = 1'b0, FlashOpEr = 1'b0;
   logic FlashCmdAck, FlashBusy, FlashError, CsrAddress, CsrRead, CsrWrite, DataWrite, DataWaitRequest;
   logic [6:0]  BufRdAddress;
   logic [15:0] BufRdData = '0;
   logic [31:0] CsrReadData = '0, CsrWriteData, DataWriteData;
   logic [17:0] DataAddress;
   always #5 Clock = ~Clock;

`ifdef FLASH_VERIFY_EN
   logic DataRead, DataReadDataValid = 1'b0;
   logic [31:0] DataReadData = '0;
   logic [31:0] fmem [logic [17:0]];
   always @(posedge Clock) begin
      if (DataWrite && !DataWaitRequest) fmem[DataAddress] <= DataWriteData;
      DataReadDataValid <= DataRead;
      DataReadData <= fmem.exists(DataAddress) ? fmem[DataAddress] : 32'h0;
   end
`endif

   flash_cmd_engine #(.ADDR_W(18), .TIMEOUT_CYCLES(TMO), .WP_BITS(5'b11111)) dut (
      .Clock(Clock), .Reset(Reset),
      .FlashOpAddr(FlashOpAddr), .FlashOpLen(FlashOpLen), .FlashOpUnlock(FlashOpUnlock),
      .FlashOpWr(FlashOpWr), .FlashOpEr(FlashOpEr),
      .FlashCmdAck(FlashCmdAck), .FlashBusy(FlashBusy), .FlashError(FlashError),
      .BufRdAddress(BufRdAddress), .BufRdData(BufRdData),
      .CsrAddress(CsrAddress), .CsrRead(CsrRead), .CsrReadData(CsrReadData),
      .CsrWrite(CsrWrite), .CsrWriteData(CsrWriteData),
      .DataAddress(DataAddress), .DataWrite(DataWrite), .DataWriteData(DataWriteData),
      .DataWaitRequest(DataWaitRequest)
`ifdef FLASH_VERIFY_EN
     ,.DataRead(DataRead), .DataReadData(DataReadData), .DataReadDataValid(DataReadDataValid)
`endif
   );

   typedef enum int {K_ACK, K_CSR, K_DWR, K_END} kind_t;
   typedef struct { kind_t kind; logic [17:0] addr; logic [31:0] data; } ev_t;
   ev_t sb[$];
   int n_check = 0, n_pass = 0;
   logic [15:0] ram [128];
   int busy_n = 0, polls_seen = 0, last_polls = 0, stall_len = 0, stall_seen = 0;
   logic er_ok = 1'b1, wr_ok = 1'b1, prev_busy = 1'b0;

   // Buffer RAM, status register and wait-request models
   assign DataWaitRequest = DataWrite && stall_seen < stall_len;
   always @(posedge Clock) begin
      BufRdData <= ram[BufRdAddress];
      stall_seen <= DataWrite && DataWaitRequest ? stall_seen + 1 : 0;
      if (CsrWrite) begin
         polls_seen <= 0;
         last_polls <= polls_seen;
      end else if (CsrRead) polls_seen <= polls_seen + 1;
      CsrReadData <= CsrRead ? (polls_seen < busy_n ? 32'h3 : {27'd0, er_ok, wr_ok, 3'd0}) : 32'h18;
   end

   task automatic push(input kind_t k, input logic [17:0] a, input logic [31:0] d);
      sb.push_back('{kind: k, addr: a, data: d});
   endtask

   task automatic check_ev(input kind_t k, input logic [17:0] a, input logic [31:0] d);
      ev_t e;
      n_check++;
      if (sb.size() == 0) begin
         $display("FAIL unexpected_%s: got addr=%h data=%h, expected no event", k.name(), a, d);
         return;
      end
      e = sb.pop_front();
      if (e.kind == k && e.addr == a && e.data == d) n_pass++;
      else $display("FAIL event_%s: got %s addr=%h data=%h, expected %s addr=%h data=%h",
                    e.kind.name(), k.name(), a, d, e.kind.name(), e.addr, e.data);
   endtask

   always @(negedge Clock) begin
      if (Reset) prev_busy = 1'b0;
      else begin
         if (FlashCmdAck) check_ev(K_ACK, 18'd0, {31'd0, FlashError});
         if (CsrWrite) check_ev(K_CSR, {17'd0, CsrAddress}, CsrWriteData);
         if (DataWrite && !DataWaitRequest) check_ev(K_DWR, DataAddress, DataWriteData);
         else if (DataWrite && sb.size() != 0 && sb[0].kind == K_DWR) begin
            n_check++;
            if (DataAddress == sb[0].addr && DataWriteData == sb[0].data) n_pass++;
            else $display("FAIL stall_stable: got addr=%h data=%h, expected addr=%h data=%h",
                          DataAddress, DataWriteData, sb[0].addr, sb[0].data);
         end
         if (prev_busy && !FlashBusy) check_ev(K_END, 18'd0, {31'd0, FlashError});
         prev_busy = FlashBusy;
      end
   end

   task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
      n_check++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
   endtask

   task automatic cmd(input logic wr, input logic er, input logic [17:0] a, input logic [5:0] l);
      FlashOpWr = wr; FlashOpEr = er; FlashOpUnlock = 1'b1; FlashOpAddr = a; FlashOpLen = l;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clock); #1;
         if (FlashCmdAck) break;
      end
      chk("ack_seen", FlashCmdAck, 1);
      FlashOpWr = 1'b0; FlashOpEr = 1'b0; FlashOpUnlock = 1'b0;
      FlashOpAddr = 18'h2AAAA; FlashOpLen = 6'd63;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(posedge Clock); #1;
         if (!FlashBusy) break;
      end
      chk("busy_falls", FlashBusy, 0);
      @(negedge Clock); #1;
      chk("sb_drained", sb.size(), 0);
   endtask

   task automatic load_ram();
      ram[0] = 16'h1111; ram[1] = 16'h2222; ram[2] = 16'h3333; ram[3] = 16'h4444;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) ram[i] = 16'h0;
      repeat (3) @(posedge Clock);
      #1;
      chk("reset_outputs", {FlashCmdAck, FlashBusy, FlashError, BufRdAddress, CsrAddress, CsrRead, CsrWrite,
                            CsrWriteData, DataAddress, DataWrite, DataWriteData}, 0);
      Reset = 1'b0;
      // erase succeeding on the third status poll
      busy_n = 2;
      push(K_ACK, 0, 0); push(K_CSR, 1, WP_OFF_W); push(K_CSR, 1, 32'hF0700400); push(K_CSR, 1, WP_ON_W); push(K_END, 0, 0);
      cmd(0, 1, 18'h00400, 0);
      wait_idle();
      chk("erase_polls", last_polls, 3);
      // erase reporting failure
      busy_n = 0; er_ok = 1'b0;
      push(K_ACK, 0, 0); push(K_CSR, 1, WP_OFF_W); push(K_CSR, 1, 32'hF073FFFF); push(K_CSR, 1, WP_ON_W); push(K_END, 0, 1);
      cmd(0, 1, 18'h3FFFF, 0);
      wait_idle();
      er_ok = 1'b1;
      // two-word write; ack shows the previous error cleared
      load_ram();
      push(K_ACK, 0, 0); push(K_CSR, 1, WP_OFF_W); push(K_DWR, 18'h10, 32'h11112222);
      push(K_DWR, 18'h11, 32'h33334444); push(K_CSR, 1, WP_ON_W); push(K_END, 0, 0);
      cmd(1, 0, 18'h10, 2);
      wait_idle();
      // 20-cycle wait request during a write
      ram[0] = 16'hABCD; ram[1] = 16'h1234; stall_len = 20;
      push(K_ACK, 0, 0); push(K_CSR, 1, WP_OFF_W); push(K_DWR, 18'h20, 32'hABCD1234); push(K_CSR, 1, WP_ON_W); push(K_END, 0, 0);
      cmd(1, 0, 18'h20, 1);
      wait_idle();
      stall_len = 0;
      // malformed commands
      push(K_ACK, 0, 1); push(K_END, 0, 1);
      cmd(1, 1, 18'h5, 1);
      wait_idle();
      push(K_ACK, 0, 1); push(K_END, 0, 1);
      cmd(1, 0, 18'h5, 0);
      wait_idle();
      // no unlock -> ignored
      FlashOpWr = 1'b1; FlashOpLen = 6'd1;
      repeat (10) @(posedge Clock);
      #1;
      chk("no_unlock_busy", FlashBusy, 0);
      FlashOpWr = 1'b0;
      // address wrap
      load_ram();
      push(K_ACK, 0, 0); push(K_CSR, 1, WP_OFF_W); push(K_DWR, 18'h3FFFF, 32'h11112222);
      push(K_DWR, 18'h00000, 32'h33334444); push(K_CSR, 1, WP_ON_W); push(K_END, 0, 0);
      cmd(1, 0, 18'h3FFFF, 2);
      wait_idle();
      // poll never completes
      busy_n = 1000;
      push(K_ACK, 0, 0); push(K_CSR, 1, WP_OFF_W); push(K_CSR, 1, 32'hF0700005); push(K_CSR, 1, WP_ON_W); push(K_END, 0, 1);
      cmd(0, 1, 18'h5, 0);
      wait_idle();
      busy_n = 0;
      // write never accepted
      stall_len = 1000;
      push(K_ACK, 0, 0); push(K_CSR, 1, WP_OFF_W); push(K_CSR, 1, WP_ON_W); push(K_END, 0, 1);
      cmd(1, 0, 18'h8, 1);
      wait_idle();
      // reset while in WR_REQ
      push(K_ACK, 0, 0); push(K_CSR, 1, WP_OFF_W);
      cmd(1, 0, 18'h7, 1);
      for (int i = 0; i < 20; i++) begin
         if (DataWrite) break;
         @(posedge Clock); #1;
      end
      chk("wr_req_reached", DataWrite, 1);
      Reset = 1'b1;
      @(posedge Clock); #1;
      chk("reset_mid_op", {FlashCmdAck, FlashBusy, FlashError, BufRdAddress, CsrAddress, CsrRead, CsrWrite,
                           CsrWriteData, DataAddress, DataWrite, DataWriteData}, 0);
      @(posedge Clock); #1;
      Reset = 1'b0; sb.delete(); stall_len = 0;
      // engine is idle again after reset
      push(K_ACK, 0, 0); push(K_CSR, 1, WP_OFF_W); push(K_CSR, 1, 32'hF0700001); push(K_CSR, 1, WP_ON_W); push(K_END, 0, 0);
      cmd(0, 1, 18'h1, 0);
      wait_idle();
      $display("%0d/%0d checks passed", n_pass, n_check);
      $finish;
   end
endmodule
